// File: rtl/swap_cfg_pkg.sv
// Shared types for the swap-stage configuration controller: FSM states,
// the redirect entry layout and the drain-timeout counter width helper.
package swap_cfg_pkg;

  // Width of the source/target fields in a redirect entry
  localparam int SWAP_LOG_N = 2;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    APPLY,
    DONE,
    ERR
  } state_e;

  typedef struct packed {
    logic                  en;
    logic [SWAP_LOG_N-1:0] source;
    logic [SWAP_LOG_N-1:0] target;
  } entry_t;

  // Bits needed to count from 0 up to cycles-1 (at least one bit)
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/swap_outstanding_cnt.sv
// Per-port outstanding-transaction counter: saturating up/down with a
// zero flag used by the commit controller to detect a fully drained port.
module swap_outstanding_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count requests up and final responses down; hold at both rails
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/swap_cfg_ctrl.sv
// Configuration and commit controller for the region-match swap stage.
// Entries are written into a shadow bank and copied atomically into the
// active bank once every initiator port has no transaction in flight.
module swap_cfg_ctrl
  import swap_cfg_pkg::*;
#(
  parameter int N_INIT_PORT    = 8,
  parameter int LOG_N_INIT     = SWAP_LOG_N,
  parameter int IDX_W          = $clog2(N_INIT_PORT),
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   cfg_valid_i,
  output logic                                   cfg_ready_o,
  input  logic [IDX_W-1:0]                       cfg_idx_i,
  input  logic                                   cfg_en_i,
  input  logic [LOG_N_INIT-1:0]                  cfg_source_i,
  input  logic [LOG_N_INIT-1:0]                  cfg_target_i,
  input  logic                                   commit_req_i,
  input  logic [N_INIT_PORT-1:0]                 req_fire_i,
  input  logic [N_INIT_PORT-1:0]                 resp_fire_i,
  output logic                                   stall_o,
  output logic                                   busy_o,
  output logic                                   commit_done_o,
  output logic                                   commit_err_o,
  output logic [N_INIT_PORT-1:0]                 select_o,
  output logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] source_o,
  output logic [N_INIT_PORT-1:0][LOG_N_INIT-1:0] target_o
);

  localparam int             TMO_W    = tmo_cnt_w(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q;
  state_e                 state_d;
  entry_t                 shadow_q [N_INIT_PORT];
  entry_t                 active_q [N_INIT_PORT];
  entry_t                 wr_entry;
  logic                   cfg_fire;
  logic                   idx_ok;
  logic [TMO_W-1:0]       tmo_q;
  logic [N_INIT_PORT-1:0] cnt_zero;
  logic                   all_drained;

  assign cfg_fire = cfg_valid_i && cfg_ready_o;
  assign idx_ok   = (int'(cfg_idx_i) < N_INIT_PORT);
  assign wr_entry = '{en: cfg_en_i, source: cfg_source_i, target: cfg_target_i};

  // One outstanding counter per initiator port; drained when all are zero
  for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_cnt
    swap_outstanding_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (req_fire_i[p]),
      .dec  (resp_fire_i[p]),
      .count(),
      .zero (cnt_zero[p])
    );
  end

  assign all_drained = &cnt_zero;

  // Shadow bank: written only while idle; out-of-range indices are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '{default: '0};
    end else if (cfg_fire && idx_ok) begin
      shadow_q[cfg_idx_i] <= wr_entry;
    end
  end

  // Active bank: takes the whole shadow bank on the edge leaving APPLY
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= '{default: '0};
    end else if (state_q == APPLY) begin
      active_q <= shadow_q;
    end
  end

  // Drain timer: counts cycles spent in DRAIN, cleared everywhere else
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == DRAIN) begin
      tmo_q <= tmo_q + TMO_W'(1);
    end else begin
      tmo_q <= '0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and status decode; a drained port set beats the timeout
  always_comb begin
    state_d       = state_q;
    cfg_ready_o   = 1'b0;
    stall_o       = 1'b0;
    busy_o        = 1'b1;
    commit_done_o = 1'b0;
    commit_err_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (commit_req_i) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        stall_o = 1'b1;
        if (all_drained) begin
          state_d = APPLY;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
        end
      end
      APPLY: begin
        stall_o = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        commit_done_o = 1'b1;
        state_d       = IDLE;
      end
      ERR: begin
        commit_err_o = 1'b1;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Unpack the active bank onto the swap-stage buses
  always_comb begin
    select_o = '0;
    source_o = '0;
    target_o = '0;
    for (int i = 0; i < N_INIT_PORT; i++) begin
      select_o[i] = active_q[i].en;
      source_o[i] = active_q[i].source;
      target_o[i] = active_q[i].target;
    end
  end

endmodule

// File: tb/tb_swap_cfg_ctrl.sv
// Self-checking bench for swap_cfg_ctrl. Each commit pushes its expected
// outcome into a scoreboard that is popped when done/err pulses.
module tb_swap_cfg_ctrl;
  import swap_cfg_pkg::*;

  localparam int N   = 8;
  localparam int LW  = 2;
  localparam int IW  = 3;
  localparam int CW  = 4;
  localparam int TMO = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_valid_i;
  logic                   cfg_ready_o;
  logic [IW-1:0]          cfg_idx_i;
  logic                   cfg_en_i;
  logic [LW-1:0]          cfg_source_i;
  logic [LW-1:0]          cfg_target_i;
  logic                   commit_req_i;
  logic [N-1:0]           req_fire_i;
  logic [N-1:0]           resp_fire_i;
  logic                   stall_o;
  logic                   busy_o;
  logic                   commit_done_o;
  logic                   commit_err_o;
  logic [N-1:0]           select_o;
  logic [N-1:0][LW-1:0]   source_o;
  logic [N-1:0][LW-1:0]   target_o;

  swap_cfg_ctrl #(
    .N_INIT_PORT(N), .LOG_N_INIT(LW), .IDX_W(IW), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
    .cfg_en_i(cfg_en_i), .cfg_source_i(cfg_source_i), .cfg_target_i(cfg_target_i),
    .commit_req_i(commit_req_i), .req_fire_i(req_fire_i), .resp_fire_i(resp_fire_i),
    .stall_o(stall_o), .busy_o(busy_o), .commit_done_o(commit_done_o),
    .commit_err_o(commit_err_o), .select_o(select_o), .source_o(source_o),
    .target_o(target_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                   is_err;
    logic [N-1:0]         sel;
    logic [N-1:0][LW-1:0] src;
    logic [N-1:0][LW-1:0] tgt;
  } exp_t;

  exp_t                 sb[$];
  int                   checks = 0;
  int                   errors = 0;
  logic [N-1:0]         sh_en,  act_en;
  logic [N-1:0][LW-1:0] sh_src, sh_tgt, act_src, act_tgt;

  // Scoreboard monitor: every done/err pulse must match the oldest commit
  always @(negedge clk) begin
    if (!rst && (commit_done_o || commit_err_o)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: done=%b err=%b required no pulse", commit_done_o, commit_err_o);
      end else begin : pop_blk
        exp_t e;
        e = sb.pop_front();
        if (commit_err_o !== e.is_err || commit_done_o !== !e.is_err ||
            select_o !== e.sel || source_o !== e.src || target_o !== e.tgt) begin
          errors++;
          $display("[TB] FAIL sb_commit: err=%b sel=%h src=%h tgt=%h required err=%b sel=%h src=%h tgt=%h",
                   commit_err_o, select_o, source_o, target_o, e.is_err, e.sel, e.src, e.tgt);
        end
        if (!e.is_err) begin
          act_en  = e.sel;
          act_src = e.src;
          act_tgt = e.tgt;
        end
      end
    end
  end

  // Run-away guard so the bench always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_model();
    sh_en = '0; sh_src = '0; sh_tgt = '0;
    act_en = '0; act_src = '0; act_tgt = '0;
    sb.delete();
  endtask

  // Stimulus: one accepted entry write while the controller is idle
  task automatic applyStimulus(input int idx, input logic en, input logic [LW-1:0] s, input logic [LW-1:0] t);
    cfg_valid_i = 1'b1; cfg_idx_i = IW'(idx); cfg_en_i = en; cfg_source_i = s; cfg_target_i = t;
    sh_en[idx] = en; sh_src[idx] = s; sh_tgt[idx] = t;
    tick();
    cfg_valid_i = 1'b0;
  endtask

  task automatic push_commit(input bit is_err);
    exp_t e;
    e.is_err = is_err;
    if (is_err) begin
      e.sel = act_en; e.src = act_src; e.tgt = act_tgt;
    end else begin
      e.sel = sh_en;  e.src = sh_src;  e.tgt = sh_tgt;
    end
    sb.push_back(e);
  endtask

  // Reset state of every output
  task automatic test_reset();
    rst = 1'b1; cfg_valid_i = 0; cfg_idx_i = 0; cfg_en_i = 0; cfg_source_i = 0; cfg_target_i = 0;
    commit_req_i = 0; req_fire_i = '0; resp_fire_i = '0;
    clear_model();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cfg_ready_o, busy_o, stall_o, commit_done_o, commit_err_o} !== 5'b10000) begin
      errors++;
      $display("[TB] FAIL reset_status: ready/busy/stall/done/err=%b required 10000",
               {cfg_ready_o, busy_o, stall_o, commit_done_o, commit_err_o});
    end
    checks++;
    if (select_o !== '0 || source_o !== '0 || target_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_active: sel=%h src=%h tgt=%h required 0", select_o, source_o, target_o);
    end
  endtask

  // Idle counters: new config visible exactly three cycles after commit
  task automatic test_basic_commit();
    applyStimulus(3, 1'b1, 2'd1, 2'd2);
    commit_req_i = 1'b1; push_commit(1'b0);
    tick();
    commit_req_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (k <= 2) begin
        if ({busy_o, stall_o, commit_done_o} !== 3'b110 || select_o !== 8'h00) begin
          errors++;
          $display("[TB] FAIL basic_c%0d: busy/stall/done=%b sel=%h required 110 sel=00",
                   k, {busy_o, stall_o, commit_done_o}, select_o);
        end
      end else if (k == 3) begin
        if (commit_done_o !== 1'b1 || stall_o !== 1'b0 || select_o !== 8'h08 ||
            source_o[3] !== 2'd1 || target_o[3] !== 2'd2) begin
          errors++;
          $display("[TB] FAIL basic_done: done=%b stall=%b sel=%h src3=%0d tgt3=%0d required 1 0 08 1 2",
                   commit_done_o, stall_o, select_o, source_o[3], target_o[3]);
        end
      end else begin
        if ({cfg_ready_o, busy_o, commit_done_o} !== 3'b100) begin
          errors++;
          $display("[TB] FAIL basic_idle: ready/busy/done=%b required 100", {cfg_ready_o, busy_o, commit_done_o});
        end
      end
      if (k < 4) tick();
    end
  endtask

  // Two outstanding on port 5: commit waits for both responses
  task automatic test_drain_wait();
    applyStimulus(5, 1'b1, 2'd3, 2'd0);
    req_fire_i[5] = 1'b1; tick(); tick(); req_fire_i = '0;
    commit_req_i = 1'b1; push_commit(1'b0);
    tick();
    commit_req_i = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      checks++;
      if (k < 23) begin
        if (stall_o !== 1'b1 || commit_done_o !== 1'b0 || select_o !== 8'h08) begin
          errors++;
          $display("[TB] FAIL drain_c%0d: stall=%b done=%b sel=%h required 1 0 08", k, stall_o, commit_done_o, select_o);
        end
      end else begin
        if (commit_done_o !== 1'b1 || stall_o !== 1'b0 || select_o !== 8'h28 ||
            source_o[5] !== 2'd3 || target_o[5] !== 2'd0) begin
          errors++;
          $display("[TB] FAIL drain_done: done=%b stall=%b sel=%h src5=%0d tgt5=%0d required 1 0 28 3 0",
                   commit_done_o, stall_o, select_o, source_o[5], target_o[5]);
        end
      end
      resp_fire_i[5] = (k == 10 || k == 20);
      if (k < 23) tick();
    end
    resp_fire_i = '0;
    tick();
  endtask

  // Port 0 never drains: abort after the timeout, then retry succeeds
  task automatic test_timeout();
    applyStimulus(6, 1'b1, 2'd2, 2'd1);
    req_fire_i[0] = 1'b1; tick(); req_fire_i = '0;
    commit_req_i = 1'b1; push_commit(1'b1);
    tick();
    commit_req_i = 1'b0;
    for (int k = 1; k <= TMO + 2; k++) begin
      checks++;
      if (k <= TMO) begin
        if (stall_o !== 1'b1 || commit_err_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL tmo_c%0d: stall=%b err=%b required 1 0", k, stall_o, commit_err_o);
        end
      end else if (k == TMO + 1) begin
        if (commit_err_o !== 1'b1 || commit_done_o !== 1'b0 || stall_o !== 1'b0 || select_o !== 8'h28) begin
          errors++;
          $display("[TB] FAIL tmo_err: err=%b done=%b stall=%b sel=%h required 1 0 0 28",
                   commit_err_o, commit_done_o, stall_o, select_o);
        end
      end else begin
        if (busy_o !== 1'b0 || commit_err_o !== 1'b0 || select_o !== 8'h28) begin
          errors++;
          $display("[TB] FAIL tmo_idle: busy=%b err=%b sel=%h required 0 0 28", busy_o, commit_err_o, select_o);
        end
      end
      if (k < TMO + 2) tick();
    end
    resp_fire_i[0] = 1'b1; tick(); resp_fire_i = '0;
    commit_req_i = 1'b1; push_commit(1'b0);
    tick();
    commit_req_i = 1'b0;
    tick(); tick();
    checks++;
    if (commit_done_o !== 1'b1 || select_o !== 8'h68 || source_o[6] !== 2'd2 || target_o[6] !== 2'd1) begin
      errors++;
      $display("[TB] FAIL tmo_retry: done=%b sel=%h src6=%0d tgt6=%0d required 1 68 2 1",
               commit_done_o, select_o, source_o[6], target_o[6]);
    end
    tick();
  endtask

  // Drain completes in the very cycle the timer hits its last value
  task automatic test_drain_timeout_tie();
    req_fire_i[4] = 1'b1; tick(); req_fire_i = '0;
    applyStimulus(1, 1'b1, 2'd0, 2'd3);
    commit_req_i = 1'b1; push_commit(1'b0);
    tick();
    commit_req_i = 1'b0;
    for (int k = 1; k <= TMO + 2; k++) begin
      checks++;
      if (k <= TMO + 1) begin
        if (stall_o !== 1'b1 || commit_err_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL tie_c%0d: stall=%b err=%b required 1 0", k, stall_o, commit_err_o);
        end
      end else begin
        if (commit_done_o !== 1'b1 || commit_err_o !== 1'b0 || select_o !== 8'h6a) begin
          errors++;
          $display("[TB] FAIL tie_done: done=%b err=%b sel=%h required 1 0 6a", commit_done_o, commit_err_o, select_o);
        end
      end
      resp_fire_i[4] = (k == TMO - 1);
      if (k < TMO + 2) tick();
    end
    resp_fire_i = '0;
    tick();
  endtask

  // Write+commit in one cycle is included; writes during DRAIN are refused
  task automatic test_back_to_back();
    req_fire_i[7] = 1'b1; tick(); req_fire_i = '0;
    cfg_valid_i = 1'b1; cfg_idx_i = 3'd2; cfg_en_i = 1'b1; cfg_source_i = 2'd1; cfg_target_i = 2'd1;
    sh_en[2] = 1'b1; sh_src[2] = 2'd1; sh_tgt[2] = 2'd1;
    commit_req_i = 1'b1; push_commit(1'b0);
    tick();
    commit_req_i = 1'b0;
    cfg_idx_i = 3'd4; cfg_source_i = 2'd3; cfg_target_i = 2'd3;
    checks++;
    if (cfg_ready_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ready: cfg_ready_o=%b required 0 in DRAIN", cfg_ready_o);
    end
    tick();
    cfg_valid_i = 1'b0;
    resp_fire_i[7] = 1'b1;
    tick();
    resp_fire_i = '0;
    tick();
    checks++;
    if (stall_o !== 1'b1 || select_o !== 8'h6a) begin
      errors++;
      $display("[TB] FAIL b2b_apply: stall=%b sel=%h required 1 6a", stall_o, select_o);
    end
    tick();
    checks++;
    if (commit_done_o !== 1'b1 || select_o !== 8'h6e || source_o[2] !== 2'd1 || source_o[4] !== 2'd0) begin
      errors++;
      $display("[TB] FAIL b2b_done: done=%b sel=%h src2=%0d src4=%0d required 1 6e 1 0",
               commit_done_o, select_o, source_o[2], source_o[4]);
    end
    tick();
  endtask

  // Outstanding counter edges: same-cycle fire, saturation, floor at zero
  task automatic test_counters();
    req_fire_i[1] = 1'b1; tick(); req_fire_i = '0;
    req_fire_i[1] = 1'b1; resp_fire_i[1] = 1'b1; tick(); req_fire_i = '0; resp_fire_i = '0;
    checks++;
    if (dut.g_cnt[1].u_cnt.count !== 4'd1) begin
      errors++;
      $display("[TB] FAIL cnt_both: count=%0d required 1", dut.g_cnt[1].u_cnt.count);
    end
    resp_fire_i[1] = 1'b1; tick(); tick(); resp_fire_i = '0;
    checks++;
    if (dut.g_cnt[1].u_cnt.count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL cnt_floor: count=%0d required 0", dut.g_cnt[1].u_cnt.count);
    end
    req_fire_i[2] = 1'b1; repeat (20) tick(); req_fire_i = '0;
    checks++;
    if (dut.g_cnt[2].u_cnt.count !== 4'd15) begin
      errors++;
      $display("[TB] FAIL cnt_sat: count=%0d required 15", dut.g_cnt[2].u_cnt.count);
    end
    resp_fire_i[2] = 1'b1; repeat (15) tick(); resp_fire_i = '0;
    checks++;
    if (dut.g_cnt[2].u_cnt.count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL cnt_unwind: count=%0d required 0", dut.g_cnt[2].u_cnt.count);
    end
  endtask

  // Reset in DRAIN discards the commit and clears the active config
  task automatic test_reset_mid_drain();
    req_fire_i[3] = 1'b1; tick(); req_fire_i = '0;
    commit_req_i = 1'b1;
    tick();
    commit_req_i = 1'b0;
    rst = 1'b1;
    clear_model();
    tick();
    checks++;
    if ({cfg_ready_o, busy_o, stall_o, commit_done_o, commit_err_o} !== 5'b10000 ||
        select_o !== '0 || source_o !== '0 || target_o !== '0) begin
      errors++;
      $display("[TB] FAIL rst_drain: status=%b sel=%h src=%h tgt=%h required 10000 and zeros",
               {cfg_ready_o, busy_o, stall_o, commit_done_o, commit_err_o}, select_o, source_o, target_o);
    end
    rst = 1'b0;
    tick();
  endtask

  // Repeated commit requests while busy are ignored: exactly one done
  task automatic test_commit_ignored();
    applyStimulus(0, 1'b1, 2'd2, 2'd3);
    commit_req_i = 1'b1; push_commit(1'b0);
    tick(); tick(); tick();
    commit_req_i = 1'b0;
    checks++;
    if (commit_done_o !== 1'b1 || select_o !== 8'h01 || target_o[0] !== 2'd3) begin
      errors++;
      $display("[TB] FAIL ign_done: done=%b sel=%h tgt0=%0d required 1 01 3", commit_done_o, select_o, target_o[0]);
    end
    tick();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ign_idle: busy=%b required 0", busy_o);
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_drain_wait();
    test_timeout();
    test_drain_timeout_tie();
    test_back_to_back();
    test_counters();
    test_reset_mid_drain();
    test_commit_ignored();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drained: %0d commits pending required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
